my_serial_adder_ctrl: RTL and testbench

- Bit-serial N-bit adder controller that uses one `my_FA` full-adder cell once per clock, LSB first, with a registered carry.
- Accepts an operand pair on a start request, runs for WIDTH cycles, then presents sum/cout with a one-cycle done pulse.
- Area-minimal alternative to a WIDTH-wide ripple adder; sits between a requester (FSM or testbench) and the shared FA cell.

---
 rtl/my_serial_adder_ctrl_pkg.sv | 13 +
 rtl/my_serial_adder_ctrl_fa.sv | 13 +
 rtl/my_serial_adder_ctrl.sv | 126 ++++++++++++
 tb/tb_my_serial_adder_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/my_serial_adder_ctrl_pkg.sv
// Shared constants for the bit-serial adder controller: FSM encoding and default sizing.
package my_serial_adder_ctrl_pkg;

   localparam int unsigned DEFAULT_WIDTH = 8;
   localparam int unsigned DEFAULT_CW    = 6;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/my_serial_adder_ctrl_fa.sv
// Single-bit full-adder cell time-shared by the serial adder controller.
module my_FA (
   input  logic ci,
   input  logic x,
   input  logic y,
   output logic s,
   output logic co
);

   assign s  = x ^ y ^ ci;
   assign co = (x & y) | (x & ci) | (y & ci);

endmodule

// File: rtl/my_serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one full-adder evaluation per clock, LSB first, registered carry.
module my_serial_adder_ctrl
   import my_serial_adder_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH,
   parameter int unsigned CW    = DEFAULT_CW
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   // Holds the WIDTH-1 low result bits; the top bit is taken straight from the cell on the last edge.
   logic [WIDTH-2:0] r_sh;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             fa_r;
   logic             fa_cout;
   logic             last_bit;
   logic             busy_nxt;
   logic             done_nxt;

   assign last_bit = (cnt == CW'(WIDTH - 1));

   my_FA u_fa (
      .ci (carry),
      .x  (a_sh[0]),
      .y  (b_sh[0]),
      .s  (fa_r),
      .co (fa_cout)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (start)    state_nxt = ST_RUN;
         ST_RUN:  if (last_bit) state_nxt = ST_DONE;
         ST_DONE:               state_nxt = ST_IDLE;
         default:               state_nxt = ST_IDLE;
      endcase
   end

   // Status decode from the next state so busy/done are flops that track the state register exactly
   always_comb begin
      busy_nxt = 1'b0;
      done_nxt = 1'b0;
      case (state_nxt)
         ST_RUN:  busy_nxt = 1'b1;
         ST_DONE: done_nxt = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         busy <= busy_nxt;
         done <= done_nxt;
      end
   end

   // Operand capture, serial shift and result commit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh  <= '0;
         b_sh  <= '0;
         r_sh  <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         sum   <= '0;
         cout  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  a_sh  <= a;
                  b_sh  <= b;
                  r_sh  <= '0;
                  carry <= cin;
                  cnt   <= '0;
               end
            end
            ST_RUN: begin
               a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
               b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
               carry <= fa_cout;
               cnt   <= cnt + CW'(1);
               if (WIDTH > 2) begin
                  r_sh <= {fa_r, r_sh[WIDTH-2:1]};
               end else begin
                  r_sh <= fa_r;
               end
               if (last_bit) begin
                  sum  <= {fa_r, r_sh};
                  cout <= fa_cout;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_my_serial_adder_ctrl.sv
// Directed self-checking bench: vector table at WIDTH=8, multi-cycle corner sequences, exhaustive WIDTH=4 sweep.
module tb_my_serial_adder_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start8, cin8, busy8, done8, cout8;
   logic [7:0] a8, b8, sum8;
   logic       start4, cin4, busy4, done4, cout4;
   logic [3:0] a4, b4, sum4;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   my_serial_adder_ctrl #(.WIDTH(8), .CW(6)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
      .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
   );

   my_serial_adder_ctrl #(.WIDTH(4), .CW(3)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
      .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
   );

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
      logic [7:0] exp_sum;
      logic       exp_cout;
   } vec_t;

   vec_t vecs [9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One WIDTH=8 operation with a single-cycle start pulse; checks busy width, result and done width.
   task automatic run8(input logic [7:0] ia, input logic [7:0] ib, input logic icin,
                       input logic [7:0] es, input logic ec, input string tag);
      int n;
      @(negedge clk);
      a8 = ia; b8 = ib; cin8 = icin; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      n = 0;
      while (busy8 && n < 40) begin
         n++;
         @(negedge clk);
      end
      check({tag, " busy_cycles"}, 32'(n), 32'd8);
      check({tag, " done"}, 32'(done8), 32'd1);
      check({tag, " sum"}, 32'(sum8), 32'(es));
      check({tag, " cout"}, 32'(cout8), 32'(ec));
      @(negedge clk);
      check({tag, " done_width"}, 32'(done8), 32'd0);
      check({tag, " sum_hold"}, 32'(sum8), 32'(es));
   endtask

   task automatic run4(input logic [3:0] ia, input logic [3:0] ib, input logic icin);
      int n;
      logic [4:0] exp;
      exp = 5'(ia) + 5'(ib) + 5'(icin);
      @(negedge clk);
      a4 = ia; b4 = ib; cin4 = icin; start4 = 1'b1;
      @(negedge clk);
      start4 = 1'b0;
      n = 0;
      while (busy4 && n < 20) begin
         n++;
         @(negedge clk);
      end
      check("w4 busy_cycles", 32'(n), 32'd4);
      check("w4 result", 32'({cout4, sum4}), 32'(exp));
      check("w4 done", 32'(done4), 32'd1);
      @(negedge clk);
      check("w4 done_width", 32'(done4), 32'd0);
   endtask

   initial begin
      int t_done [3];
      int k, cyc;

      vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
      vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
      vecs[2] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
      vecs[3] = '{8'd100, 8'd27, 1'b0, 8'd127, 1'b0};
      vecs[4] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
      vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
      vecs[6] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
      vecs[7] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0};
      vecs[8] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0};

      rst_n = 1'b0;
      start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
      start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
      #2;
      check("reset busy", 32'(busy8), 32'd0);
      check("reset done", 32'(done8), 32'd0);
      check("reset sum", 32'(sum8), 32'd0);
      check("reset cout", 32'(cout8), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 9; i++) begin
         run8(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].exp_sum, vecs[i].exp_cout,
              $sformatf("vec%0d", i));
      end

      // start held high: back-to-back operations every WIDTH+2 cycles
      @(negedge clk);
      a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
      k = 0; cyc = 0;
      while (k < 3 && cyc < 60) begin
         @(negedge clk);
         cyc++;
         if (done8) begin
            t_done[k] = cyc;
            check("held sum", 32'(sum8), 32'h10);
            k++;
         end
      end
      check("held done_count", 32'(k), 32'd3);
      check("held interval1", 32'(t_done[1] - t_done[0]), 32'd10);
      check("held interval2", 32'(t_done[2] - t_done[1]), 32'd10);
      start8 = 1'b0;
      repeat (12) @(negedge clk);

      // operand changes and start pulses during RUN are ignored
      a8 = 8'h20; b8 = 8'h03; cin8 = 1'b0; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      repeat (2) @(negedge clk);
      a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      cyc = 0;
      while (!done8 && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      check("midrun done", 32'(done8), 32'd1);
      check("midrun sum", 32'(sum8), 32'h23);
      check("midrun cout", 32'(cout8), 32'd0);
      repeat (3) begin
         @(negedge clk);
         check("midrun no_restart", 32'(busy8), 32'd0);
      end

      // reset at RUN bit 4 aborts with cleared outputs and no done pulse
      a8 = 8'h55; b8 = 8'h11; start8 = 1'b1; cin8 = 1'b0;
      @(negedge clk);
      start8 = 1'b0;
      repeat (4) @(negedge clk);
      check("abort pre busy", 32'(busy8), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("abort busy", 32'(busy8), 32'd0);
      check("abort done", 32'(done8), 32'd0);
      check("abort sum", 32'(sum8), 32'd0);
      check("abort cout", 32'(cout8), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      k = 0;
      repeat (12) begin
         @(negedge clk);
         if (done8 || busy8) k++;
      end
      check("abort no_activity", 32'(k), 32'd0);
      run8(8'd3, 8'd4, 1'b0, 8'd7, 1'b0, "post_abort");

      // exhaustive WIDTH=4
      for (int ia = 0; ia < 16; ia++)
         for (int ib = 0; ib < 16; ib++)
            for (int ic = 0; ic < 2; ic++)
               run4(4'(ia), 4'(ib), 1'(ic));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
